gpr_wb_multiport: RTL and testbench

//  Next-generation write-back register file: R/F/M register groups with NWB write-back channels,

---
 rtl/gpr_wb_multiport_pkg.sv | 30 +++
 rtl/gpr_wb_multiport_rr_arb.sv | 65 ++++++
 rtl/gpr_wb_multiport.sv | 227 ++++++++++++++++++++++
 tb/tb_gpr_wb_multiport.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_multiport_pkg.sv
// ----------------------------------------------------------------------------
// gpr_wb_multiport_pkg
//   Shared definitions for the multi-port write-back register file:
//   register group encodings, group slot indices used for the per-group
//   arrays inside the top level, and a small width helper.
// ----------------------------------------------------------------------------
package gpr_wb_multiport_pkg;

  // Group encoding carried on wb_group / iss_group / rd_group.
  typedef enum logic [1:0] {
    REG_GROUP_R       = 2'd0,
    REG_GROUP_F       = 2'd1,
    REG_GROUP_M       = 2'd2,
    REG_GROUP_INVALID = 2'd3
  } reg_group_e;

  // Number of real register groups and their slots in per-group arrays.
  // Slot numbers match the group encodings so a group value can be compared
  // directly against a slot number.
  localparam int NGRP = 3;
  localparam int GR   = 0;
  localparam int GF   = 1;
  localparam int GM   = 2;

  // Width of an index into n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpr_wb_multiport_rr_arb.sv
// ----------------------------------------------------------------------------
// gpr_wb_rr_arb
//   Round-robin arbiter for one register group. Takes one request bit per
//   write-back channel and returns a one-hot grant. The search starts at the
//   pointer; after a grant to channel c the pointer moves to (c+1) % NWB, and
//   it holds when nothing is granted. With NWB = 1 the grant equals the
//   request.
//
// Ports
//   clk    in   1     clock
//   rst    in   1     synchronous reset, active-high (pointer -> 0)
//   req    in   NWB   channel requests for this group
//   grant  out  NWB   one-hot grant (all zero when no request)
// ----------------------------------------------------------------------------
module gpr_wb_rr_arb
  import gpr_wb_multiport_pkg::*;
#(
  parameter int NWB = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NWB-1:0] req,
  output logic [NWB-1:0] grant
);

  localparam int PW = idx_width(NWB);

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_nxt;
  logic [2*NWB-1:0] req_dbl;
  logic [2*NWB-1:0] req_rot;
  logic             found;
  int               gsel;

  // Rotating the doubled request vector by the pointer puts the highest
  // priority channel at bit 0, so the search loop uses constant indices only.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl >> ptr;

  always_comb begin
    found   = 1'b0;
    gsel    = 0;
    grant   = '0;
    ptr_nxt = ptr;
    for (int k = 0; k < NWB; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        gsel  = (int'(ptr) + k) % NWB;
      end
    end
    if (found) begin
      grant   = NWB'(1) << gsel;
      ptr_nxt = PW'((gsel + 1) % NWB);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/gpr_wb_multiport.sv
// ----------------------------------------------------------------------------
// gpr_wb_multiport
//   Write-back register file with three groups (R and F: XLEN wide, M: MLEN
//   wide), NWB valid/ready write-back channels, one round-robin arbiter per
//   group and a pending-write scoreboard that the issue stage sets and fired
//   writes clear. At most one write per group per cycle, so up to three
//   writes land per cycle.
//
//   Optional feature macro: GPR_WB_BYPASS_EN
//     defined   : reads see a same-cycle firing write to the same register
//                 (combinational forwarding) and rd_busy reads 0 for it.
//     undefined : reads return the stored value; writes show up next cycle.
//
// Ports
//   clk          in   1          clock
//   rst          in   1          synchronous reset, active-high
//   wb_valid     in   NWB        channel offers a write
//   wb_ready     out  NWB        channel write accepted this cycle
//   wb_group     in   2*NWB      target group per channel
//   wb_index     in   IW*NWB     target index per channel
//   wb_data      in   MLEN*NWB   data per channel (R/F use low XLEN bits)
//   iss_valid    in   1          issue stage reserves a destination
//   iss_group    in   2          reserved group
//   iss_index    in   IW         reserved index
//   rd_group     in   2*NRD      read group per port
//   rd_index     in   IW*NRD     read index per port
//   rd_data      out  MLEN*NRD   read data (R/F zero-extended, 0 if INVALID)
//   rd_busy      out  NRD        destination reserved, write not yet retired
//   sb_any_busy  out  1          OR of all scoreboard bits
// ----------------------------------------------------------------------------
module gpr_wb_multiport
  import gpr_wb_multiport_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int MLEN = 512,
  parameter int NREG = 32,
  parameter int NWB  = 2,
  parameter int NRD  = 3,
  localparam int IW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWB-1:0]       wb_valid,
  output logic [NWB-1:0]       wb_ready,
  input  logic [2*NWB-1:0]     wb_group,
  input  logic [IW*NWB-1:0]    wb_index,
  input  logic [MLEN*NWB-1:0]  wb_data,
  input  logic                 iss_valid,
  input  logic [1:0]           iss_group,
  input  logic [IW-1:0]        iss_index,
  input  logic [2*NRD-1:0]     rd_group,
  input  logic [IW*NRD-1:0]    rd_index,
  output logic [MLEN*NRD-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic                 sb_any_busy
);

  // Per-channel views of the flattened write-back buses.
  logic [1:0]      ch_group [NWB];
  logic [IW-1:0]   ch_index [NWB];
  logic [MLEN-1:0] ch_data  [NWB];

  // Per-group arbitration and the resulting single write per group.
  logic [NWB-1:0]  req   [NGRP];
  logic [NWB-1:0]  grant [NGRP];
  logic            we    [NGRP];
  logic [IW-1:0]   widx  [NGRP];
  logic [MLEN-1:0] wdat  [NGRP];

  // Storage and scoreboard.
  logic [XLEN-1:0] r_q [NREG];
  logic [XLEN-1:0] f_q [NREG];
  logic [MLEN-1:0] m_q [NREG];
  logic [NREG-1:0] busy_q [NGRP];
  logic [NREG-1:0] busy_d [NGRP];

  always_comb begin
    for (int c = 0; c < NWB; c++) begin
      ch_group[c] = wb_group[2*c +: 2];
      ch_index[c] = wb_index[IW*c +: IW];
      ch_data[c]  = wb_data[MLEN*c +: MLEN];
    end
    for (int g = 0; g < NGRP; g++) begin
      req[g] = '0;
      for (int c = 0; c < NWB; c++) begin
        req[g][c] = wb_valid[c] && (ch_group[c] == 2'(g));
      end
    end
  end

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_arb
    gpr_wb_rr_arb #(
      .NWB (NWB)
    ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req[gi]),
      .grant (grant[gi])
    );
  end

  // An INVALID group is always accepted and then dropped; nothing downstream
  // looks at it because no arbiter requests it.
  always_comb begin
    wb_ready = '0;
    for (int c = 0; c < NWB; c++) begin
      wb_ready[c] = !rst && ((ch_group[c] == REG_GROUP_INVALID) ||
                             grant[GR][c] || grant[GF][c] || grant[GM][c]);
    end
  end

  // Grants are one-hot, so at most one channel drives each group's write.
  always_comb begin
    for (int g = 0; g < NGRP; g++) begin
      we[g]   = 1'b0;
      widx[g] = '0;
      wdat[g] = '0;
      for (int c = 0; c < NWB; c++) begin
        if (grant[g][c] && wb_ready[c]) begin
          we[g]   = 1'b1;
          widx[g] = ch_index[c];
          wdat[g] = ch_data[c];
        end
      end
    end
  end

  // R[0] is hard zero: never written, so its reset value sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_q[i] <= '0;
        f_q[i] <= '0;
        m_q[i] <= '0;
      end
    end else begin
      if (we[GR] && (widx[GR] != '0)) r_q[widx[GR]] <= wdat[GR][XLEN-1:0];
      if (we[GF])                     f_q[widx[GF]] <= wdat[GF][XLEN-1:0];
      if (we[GM])                     m_q[widx[GM]] <= wdat[GM];
    end
  end

  // Clear on fire first, then set on issue, so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    for (int g = 0; g < NGRP; g++) begin
      for (int i = 0; i < NREG; i++) begin
        if (we[g] && (widx[g] == IW'(i))) busy_d[g][i] = 1'b0;
        if (iss_valid && (iss_group == 2'(g)) && (iss_index == IW'(i))) busy_d[g][i] = 1'b1;
      end
    end
    busy_d[GR][0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < NGRP; g++) busy_q[g] <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    sb_any_busy = 1'b0;
    for (int g = 0; g < NGRP; g++) sb_any_busy = sb_any_busy | (|busy_q[g]);
  end

  // Read ports: registered state, optionally overridden by a firing write.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      logic [1:0]      grp;
      logic [IW-1:0]   idx;
      logic [MLEN-1:0] val;
      logic            bsy;
      grp = rd_group[2*p +: 2];
      idx = rd_index[IW*p +: IW];
      val = '0;
      bsy = 1'b0;
      case (grp)
        REG_GROUP_R: begin
          val = MLEN'(r_q[idx]);
          bsy = busy_q[GR][idx];
        end
        REG_GROUP_F: begin
          val = MLEN'(f_q[idx]);
          bsy = busy_q[GF][idx];
        end
        REG_GROUP_M: begin
          val = m_q[idx];
          bsy = busy_q[GM][idx];
        end
        default: begin
          val = '0;
          bsy = 1'b0;
        end
      endcase
`ifdef GPR_WB_BYPASS_EN
      case (grp)
        REG_GROUP_R: begin
          if (we[GR] && (widx[GR] == idx) && (idx != '0)) begin
            val = MLEN'(wdat[GR][XLEN-1:0]);
            bsy = 1'b0;
          end
        end
        REG_GROUP_F: begin
          if (we[GF] && (widx[GF] == idx)) begin
            val = MLEN'(wdat[GF][XLEN-1:0]);
            bsy = 1'b0;
          end
        end
        REG_GROUP_M: begin
          if (we[GM] && (widx[GM] == idx)) begin
            val = wdat[GM];
            bsy = 1'b0;
          end
        end
        default: ;
      endcase
`endif
      rd_data[MLEN*p +: MLEN] = val;
      rd_busy[p]              = bsy;
    end
  end

endmodule

// File: tb/tb_gpr_wb_multiport.sv
// ----------------------------------------------------------------------------
// tb_gpr_wb_multiport
//   Directed bench for gpr_wb_multiport with default parameters. Inputs are
//   driven 1 time unit after the rising edge, outputs are sampled 1 unit
//   later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_gpr_wb_multiport;
  import gpr_wb_multiport_pkg::*;

  localparam int XLEN = 32;
  localparam int MLEN = 512;
  localparam int NREG = 32;
  localparam int NWB  = 2;
  localparam int NRD  = 3;
  localparam int IW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NWB-1:0]      wb_valid;
  logic [NWB-1:0]      wb_ready;
  logic [2*NWB-1:0]    wb_group;
  logic [IW*NWB-1:0]   wb_index;
  logic [MLEN*NWB-1:0] wb_data;
  logic                iss_valid;
  logic [1:0]          iss_group;
  logic [IW-1:0]       iss_index;
  logic [2*NRD-1:0]    rd_group;
  logic [IW*NRD-1:0]   rd_index;
  logic [MLEN*NRD-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                sb_any_busy;

  int checks   = 0;
  int failures = 0;

  logic [MLEN-1:0] mdata;
  logic [MLEN-1:0] mdata2;

  gpr_wb_multiport #(
    .XLEN (XLEN),
    .MLEN (MLEN),
    .NREG (NREG),
    .NWB  (NWB),
    .NRD  (NRD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_group    (wb_group),
    .wb_index    (wb_index),
    .wb_data     (wb_data),
    .iss_valid   (iss_valid),
    .iss_group   (iss_group),
    .iss_index   (iss_index),
    .rd_group    (rd_group),
    .rd_index    (rd_index),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .sb_any_busy (sb_any_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MLEN-1:0] obs, input logic [MLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input int c, input logic v, input logic [1:0] g, input logic [IW-1:0] i,
                    input logic [MLEN-1:0] d);
    wb_valid[c]             = v;
    wb_group[2*c +: 2]      = g;
    wb_index[IW*c +: IW]    = i;
    wb_data[MLEN*c +: MLEN] = d;
  endtask

  task automatic rd(input int p, input logic [1:0] g, input logic [IW-1:0] i);
    rd_group[2*p +: 2]   = g;
    rd_index[IW*p +: IW] = i;
  endtask

  task automatic wb_clear();
    wb_valid  = '0;
    wb_group  = '0;
    wb_index  = '0;
    wb_data   = '0;
    iss_valid = 1'b0;
    iss_group = '0;
    iss_index = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mdata  = {16{32'hC0DE_0002}};
    mdata2 = {16{32'h1357_9BDF}};
    rst = 1'b1;
    wb_clear();
    rd_group = '0;
    rd_index = '0;
    tick();
    tick();
    #1;
    chk("reset_ready", wb_ready, 2'b00);
    chk("reset_busy_any", sb_any_busy, 1'b0);
    rst = 1'b0;

    // 1: write R3, then reset clears it and blocks ready
    wb(0, 1'b1, REG_GROUP_R, 5'd3, 'h55);
    #1 chk("t1_ready_ch0", wb_ready, 2'b01);
    tick();
    rd(0, REG_GROUP_R, 5'd3);
    #1 chk("t1_r3_written", rd_data[0 +: MLEN], 'h55);
    rst = 1'b1;
    #1 chk("t1_ready_in_rst", wb_ready, 2'b00);
    tick();
    rst = 1'b0;
    wb_clear();
    #1;
    chk("t1_r3_after_rst", rd_data[0 +: MLEN], 0);
    chk("t1_rd_busy_after_rst", rd_busy, 3'b000);
    chk("t1_any_busy_after_rst", sb_any_busy, 1'b0);

    // 2: ch0 and ch1 both write R5, two cycles
    wb(0, 1'b1, REG_GROUP_R, 5'd5, 'hA);
    wb(1, 1'b1, REG_GROUP_R, 5'd5, 'hB);
    rd(0, REG_GROUP_R, 5'd5);
    #1 chk("t2_cyc1_ready", wb_ready, 2'b01);
    tick();
    #1;
    chk("t2_cyc2_ready", wb_ready, 2'b10);
    chk("t2_r5_is_a", rd_data[0 +: MLEN], 'hA);
    tick();
    wb_clear();
    #1 chk("t2_r5_is_b", rd_data[0 +: MLEN], 'hB);

    // 3: R7 and F7 in the same cycle
    wb(0, 1'b1, REG_GROUP_R, 5'd7, 'h11);
    wb(1, 1'b1, REG_GROUP_F, 5'd7, 'h22);
    #1 chk("t3_ready_both", wb_ready, 2'b11);
    tick();
    wb_clear();
    rd(0, REG_GROUP_R, 5'd7);
    rd(1, REG_GROUP_F, 5'd7);
    #1;
    chk("t3_r7", rd_data[0 +: MLEN], 'h11);
    chk("t3_f7", rd_data[MLEN +: MLEN], 'h22);

    // 4: scoreboard on M2
    rd(2, REG_GROUP_M, 5'd2);
    iss_valid = 1'b1;
    iss_group = REG_GROUP_M;
    iss_index = 5'd2;
    #1 chk("t4_busy_not_same_cycle", rd_busy[2], 1'b0);
    tick();
    wb_clear();
    #1;
    chk("t4_busy_set", rd_busy[2], 1'b1);
    chk("t4_any_busy_set", sb_any_busy, 1'b1);
    wb(1, 1'b1, REG_GROUP_M, 5'd2, mdata);
    #1 chk("t4_ready_ch1", wb_ready, 2'b10);
    tick();
    wb_clear();
    #1;
    chk("t4_busy_cleared", rd_busy[2], 1'b0);
    chk("t4_any_busy_cleared", sb_any_busy, 1'b0);
    chk("t4_m2_data", rd_data[2*MLEN +: MLEN], mdata);
    wb(1, 1'b1, REG_GROUP_M, 5'd2, mdata2);
    iss_valid = 1'b1;
    iss_group = REG_GROUP_M;
    iss_index = 5'd2;
    tick();
    wb_clear();
    #1;
    chk("t4_iss_wins", rd_busy[2], 1'b1);
    chk("t4_m2_data2", rd_data[2*MLEN +: MLEN], mdata2);
    wb(0, 1'b1, REG_GROUP_M, 5'd2, mdata);
    tick();
    wb_clear();
    #1 chk("t4_busy_drained", sb_any_busy, 1'b0);

    // 5: R0 write/issue ignored, INVALID accepted and dropped
    wb(0, 1'b1, REG_GROUP_R, 5'd0, 'hFFFF_FFFF);
    wb(1, 1'b1, REG_GROUP_INVALID, 5'd5, 'h99);
    iss_valid = 1'b1;
    iss_group = REG_GROUP_R;
    iss_index = 5'd0;
    #1 chk("t5_ready_both", wb_ready, 2'b11);
    tick();
    wb_clear();
    rd(0, REG_GROUP_R, 5'd0);
    rd(1, REG_GROUP_R, 5'd5);
    rd(2, REG_GROUP_INVALID, 5'd5);
    #1;
    chk("t5_r0_zero", rd_data[0 +: MLEN], 0);
    chk("t5_r0_not_busy", rd_busy[0], 1'b0);
    chk("t5_any_busy", sb_any_busy, 1'b0);
    chk("t5_r5_untouched", rd_data[MLEN +: MLEN], 'hB);
    chk("t5_invalid_read", rd_data[2*MLEN +: MLEN], 0);

    // 6: write F4 while reading it
    wb(0, 1'b1, REG_GROUP_F, 5'd4, 'h3F80_0000);
    rd(1, REG_GROUP_F, 5'd4);
    #1;
`ifdef GPR_WB_BYPASS_EN
    chk("t6_same_cycle", rd_data[MLEN +: MLEN], 'h3F80_0000);
`else
    chk("t6_same_cycle", rd_data[MLEN +: MLEN], 0);
`endif
    tick();
    wb_clear();
    #1 chk("t6_next_cycle", rd_data[MLEN +: MLEN], 'h3F80_0000);

    // F pointer: ch1 granted in test 3 -> 0, ch0 granted in test 6 -> 1
    wb(0, 1'b1, REG_GROUP_F, 5'd9, 'h1);
    wb(1, 1'b1, REG_GROUP_F, 5'd9, 'h2);
    #1 chk("rr_f_ptr_ch1", wb_ready, 2'b10);
    tick();
    wb_clear();
    rd(1, REG_GROUP_F, 5'd9);
    #1 chk("rr_f9", rd_data[MLEN +: MLEN], 'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
